// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and sequencer state type for the seven-segment display chain.
package seg_pkg;
  localparam int DISP_W = 20;
  localparam logic [DISP_W-1:0] BCD_MAX = 20'd999999;
  typedef enum logic [2:0] {ISSUE, WAIT, CAPTURE, RUN_WAIT, PAUSED} seq_state_e;
endpackage

// File: rtl/step_timer.sv
// step_timer: free-running period counter with synchronous clear and terminal-count flag.
module step_timer #(
  parameter int STEP_CNT = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = $clog2(STEP_CNT);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign tc = cnt_q == CW'(STEP_CNT - 1);
endmodule

// File: rtl/rom_disp_seq.sv
// rom_disp_seq: walks a synchronous ROM on a period timer and presents each word, clamped to
// 0..999999, to the display chain; pause toggles auto-advance, step advances one word while paused.
module rom_disp_seq
  import seg_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int DATA_W   = 20,
  parameter int RD_LAT   = 2,
  parameter int STEP_CNT = 50_000_000
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              pause_key,
  input  logic              step_key,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd_en,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DISP_W-1:0] display_val_bin,
  output logic              running
);
  seq_state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_nxt;
  logic [DISP_W-1:0] disp_q, disp_d, rom_ext;
  logic [15:0] wcnt_q, wcnt_d;
  logic rd_en_q, rd_en_d, run_q, run_d, tmr_clr, tc;

  assign rom_ext  = DISP_W'(rom_q);
  assign addr_nxt = addr_q == ADDR_W'(DEPTH - 1) ? '0 : addr_q + ADDR_W'(1);

  // The strobe is registered, so every entry into ISSUE pre-arms it; after reset ISSUE spends
  // one cycle arming before the read of address 0 goes out.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    disp_d  = disp_q;
    rd_en_d = 1'b0;
    wcnt_d  = wcnt_q + 16'd1;
    run_d   = pause_key ? ~run_q : run_q;
    case (state_q)
      ISSUE:
        if (rd_en_q) begin
          state_d = RD_LAT == 1 ? CAPTURE : WAIT;
          wcnt_d  = '0;
        end else rd_en_d = 1'b1;
      WAIT:    state_d = wcnt_q == 16'(RD_LAT - 2) ? CAPTURE : WAIT;
      CAPTURE: begin
        disp_d  = rom_ext > BCD_MAX ? BCD_MAX : rom_ext;
        state_d = run_d ? RUN_WAIT : PAUSED;
      end
      RUN_WAIT:
        if (pause_key) state_d = PAUSED;
        else if (tc) begin
          state_d = ISSUE;
          addr_d  = addr_nxt;
          rd_en_d = 1'b1;
        end
      PAUSED:
        if (pause_key) state_d = RUN_WAIT;
        else if (step_key) begin
          state_d = ISSUE;
          addr_d  = addr_nxt;
          rd_en_d = 1'b1;
        end
      default: state_d = ISSUE;
    endcase
    tmr_clr = state_d == ISSUE || (state_q == PAUSED && state_d == RUN_WAIT);
  end

  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ISSUE;
      addr_q  <= '0;
      disp_q  <= '0;
      rd_en_q <= 1'b0;
      run_q   <= 1'b1;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      disp_q  <= disp_d;
      rd_en_q <= rd_en_d;
      run_q   <= run_d;
      wcnt_q  <= wcnt_d;
    end

  step_timer #(.STEP_CNT(STEP_CNT)) u_timer (
    .clk  (sys_clk),
    .rst_n(rst_n),
    .clr  (tmr_clr),
    .en   (1'b1),
    .tc   (tc)
  );

  assign rom_addr        = addr_q;
  assign rom_rd_en       = rd_en_q;
  assign display_val_bin = disp_q;
  assign running         = run_q;
endmodule
